instr_realign_buffer: RTL
=========================

INSTR_REALIGN_BUFFER -- requirements
Module: instr_realign_buffer

Interface
REQ-001 SHALL have parameter FETCH_HW, default 2, meaning 16-bit halfwords per fetch word; legal values 2 and 4.
REQ-002 SHALL have parameter DEPTH_HW, default 8, meaning buffer capacity in halfwords; power of 2 and >= 2*FETCH_HW.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all buffered halfwords and restart at flush_pc_i.
REQ-006 SHALL have port flush_pc_i, input, 32 bits: restart PC, sampled when flush_i=1.
REQ-007 SHALL have port fetch_valid_i, input, 1 bit: fetch_data_i is valid.
REQ-008 SHALL have port fetch_ready_o, output, 1 bit: buffer can accept a full fetch word.
REQ-009 SHALL have port fetch_data_i, input, 16*FETCH_HW bits: fetch word, lowest address in bits [15:0].
REQ-010 SHALL have port instr_valid_o, output, 1 bit: instr_o holds a complete instruction.
REQ-011 SHALL have port instr_ready_i, input, 1 bit: consumer accepts instr_o.
REQ-012 SHALL have port instr_o, output, 32 bits: aligned raw instruction; compressed instructions are zero-extended.
REQ-013 SHALL have port instr_pc_o, output, 32 bits: address of instr_o.
REQ-014 SHALL have port is_compressed_o, output, 1 bit: instr_o[1:0] != 2'b11.
REQ-015 SHALL have port count_o, output, clog2(DEPTH_HW)+1 bits: number of buffered halfwords.

Function
REQ-016 SHALL store halfwords in a circular buffer with read pointer, write pointer and count; the pointers SHALL wrap modulo DEPTH_HW.
REQ-017 SHALL drive fetch_ready_o = (DEPTH_HW - count) >= FETCH_HW, from registered state only, with no combinational path from instr_ready_i.
REQ-018 SHALL push on fetch_valid_i & fetch_ready_o & ~flush_i: write FETCH_HW - drop halfwords, then clear drop.
REQ-019 SHALL treat the head halfword as compressed (head[1:0] != 2'b11) or as the low half of a 32-bit instruction.
REQ-020 SHALL drive instr_valid_o = ~flush_i & (count>=2 | (count==1 & head compressed)).
REQ-021 SHALL drive instr_o = {16'h0, hw0} when the head is compressed, else {hw1, hw0}, where hw0 is the head and hw1 is the head+1 slot (wrapped).
REQ-022 SHALL pop on instr_valid_o & instr_ready_i: 1 halfword and PC+2 if compressed, else 2 halfwords and PC+4; PC arithmetic SHALL be 32-bit modulo.
REQ-023 SHALL allow a push and a pop in the same cycle: count_next = count + pushed - popped.
REQ-024 SHALL never overflow or underflow; a push is only accepted when free space >= FETCH_HW.
REQ-025 SHALL, on a 32-bit instruction split across fetch words, hold instr_valid_o=0 with count==1 until the next push, then present it in the following cycle.
REQ-026 SHALL have latency 1: a word pushed at edge N is visible on instr_* in cycle N+1; instr_* are combinational from buffer state.
REQ-027 SHALL, on flush_i=1, at the edge: count, rd and wr go to 0; pc = {flush_pc_i[31:1], 1'b0}; drop = flush_pc_i[clog2(FETCH_HW):1].
REQ-028 SHALL, on flush_i=1, ignore any fetch word offered in that cycle and perform no pop.
REQ-029 SHALL discard the low `drop` halfwords of the first fetch word accepted after a flush.
REQ-030 SHALL give flush_i priority over push and pop; rst_i SHALL have priority over flush_i.

Reset
REQ-031 SHALL, while rst_i=1 at a rising edge, clear count, rd, wr, drop and pc to 0.
REQ-032 SHALL, after reset, drive: instr_valid_o=0, count_o=0, fetch_ready_o=1, instr_pc_o=0, instr_o=0, is_compressed_o=0.
REQ-033 SHALL, when reset is asserted mid-operation, discard buffered halfwords without emitting them.

Verification (FETCH_HW=2, DEPTH_HW=8)
REQ-034 SHALL cover reset: rst_i=1 for 2 cycles -> instr_valid_o=0, count_o=0, fetch_ready_o=1.
REQ-035 SHALL cover paired compressed: flush pc 0x100, push 32'h4581_4505, instr_ready_i=1 -> next cycle instr_o=0x0000_4505 / pc 0x100 / compressed=1, then 0x0000_4581 / pc 0x102, then valid=0.
REQ-036 SHALL cover a split instruction: flush pc 0x100, push 32'h0093_4505 -> 0x4505 @0x100, then valid=0 with count_o=1; push 32'h4581_0010 -> instr_o=0x0010_0093 @0x102 compressed=0, then 0x4581 @0x106.
REQ-037 SHALL cover a mid-word start: flush pc 0x202, push 32'h4505_FFFF -> only 0x4505 @0x202; count_o reaches 1, then 0.
REQ-038 SHALL cover backpressure: instr_ready_i=0, push 4 words -> count_o=8, fetch_ready_o=0, 5th word not accepted; flush pc 0x300 -> next cycle count_o=0, instr_valid_o=0, fetch_ready_o=1.
REQ-039 SHALL cover simultaneous events and reset: a push and a 32-bit pop in the same cycle at count 4 -> count_o=4 and pointers wrap correctly past index 7; rst_i with flush_i in the same cycle -> pc 0.

Source files
------------

// File: rtl/instr_realign_buffer.sv
// Halfword realignment buffer between an instruction fetch port and a decoder.
// Mixes 16-bit compressed and 32-bit instructions out of fixed-width fetch words.
module instr_realign_buffer #(
  parameter int FETCH_HW = 2,
  parameter int DEPTH_HW = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [31:0]               flush_pc_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [16*FETCH_HW-1:0]    fetch_data_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [31:0]               instr_o,
  output logic [31:0]               instr_pc_o,
  output logic                      is_compressed_o,
  output logic [$clog2(DEPTH_HW):0] count_o
);

  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = $clog2(FETCH_HW);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH_HW - FETCH_HW);

  if (!(FETCH_HW == 2 || FETCH_HW == 4)) begin : g_bad_fetch_hw
    $error("instr_realign_buffer: FETCH_HW must be 2 or 4");
  end
  if ((DEPTH_HW & (DEPTH_HW - 1)) != 0 || DEPTH_HW < 2 * FETCH_HW) begin : g_bad_depth_hw
    $error("instr_realign_buffer: DEPTH_HW must be a power of 2 and >= 2*FETCH_HW");
  end

  logic [15:0]       buf_q [DEPTH_HW];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  push_n, pop_n;
  logic [31:0]       pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [15:0]       hw0, hw1;
  logic              head_c;
  logic              push_en, pop_en;
  logic [PTR_W-1:0]  wr_idx [FETCH_HW];
  logic [FETCH_HW-1:0] wr_en;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = flush_pc_i[0];

  // Ready depends only on registered occupancy, never on the consumer side.
  assign fetch_ready_o = (count_q <= FILL_MAX);

  assign rd_nxt = rd_q + PTR_W'(1);
  assign hw0    = buf_q[rd_q];
  assign hw1    = buf_q[rd_nxt];
  assign head_c = (hw0[1:0] != 2'b11);

  assign instr_valid_o = ~flush_i &
                         ((count_q >= CNT_W'(2)) | ((count_q == CNT_W'(1)) & head_c));

  // Outputs are forced to zero when nothing complete is presented, so stale
  // or uninitialised slots never leak onto instr_o.
  always_comb begin
    instr_o = 32'h0;
    if (instr_valid_o) begin
      instr_o = head_c ? {16'h0, hw0} : {hw1, hw0};
    end
  end

  assign is_compressed_o = instr_valid_o & head_c;
  assign instr_pc_o      = pc_q;
  assign count_o         = count_q;

  assign push_en = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop_en  = instr_valid_o & instr_ready_i;
  assign push_n  = push_en ? (CNT_W'(FETCH_HW) - CNT_W'(drop_q)) : '0;
  assign pop_n   = pop_en ? (head_c ? CNT_W'(1) : CNT_W'(2)) : '0;

  // Halfword k of the fetch word lands k-drop slots past the write pointer.
  always_comb begin
    for (int k = 0; k < FETCH_HW; k++) begin
      wr_en[k]  = push_en & (DROP_W'(k) >= drop_q);
      wr_idx[k] = wr_q + PTR_W'(k) - PTR_W'(drop_q);
    end
  end

  always_comb begin
    count_d = count_q + push_n - pop_n;
    rd_d    = rd_q + PTR_W'(pop_n);
    wr_d    = wr_q + PTR_W'(push_n);
    pc_d    = pc_q;
    drop_d  = push_en ? '0 : drop_q;
    if (pop_en) begin
      pc_d = pc_q + (head_c ? 32'd2 : 32'd4);
    end
    if (flush_i) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = {flush_pc_i[31:1], 1'b0};
      drop_d  = flush_pc_i[DROP_W:1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      pc_q    <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_HW; k++) begin
      if (wr_en[k]) begin
        buf_q[wr_idx[k]] <= fetch_data_i[16*k +: 16];
      end
    end
  end

endmodule
